chimera_cluster_pwr_seq: RTL and testbench



---
 rtl/chimera_cluster_pwr_seq.sv | 219 +++++++++++++++++++++
 tb/tb_chimera_cluster_pwr_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders clock gate, reset and AXI isolation for each cluster,
// with an isolation-ack handshake and a shared programmable timeout, configured over APB.

package chimera_cluster_pwr_seq_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

endpackage

module chimera_cluster_pwr_seq #(
  parameter int unsigned            NumClusters     = 5,
  parameter int unsigned            ClkSettleCycles = 4,
  parameter logic [15:0]            DefaultTimeout  = 16'd256,
  parameter logic [NumClusters-1:0] BootOnMask      = '0,
  parameter type                    apb_req_t       = chimera_cluster_pwr_seq_pkg::apb_req_t,
  parameter type                    apb_rsp_t       = chimera_cluster_pwr_seq_pkg::apb_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  apb_req_t               apb_req_i,
  output apb_rsp_t               apb_rsp_o,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] cluster_iso_o,
  input  logic [NumClusters-1:0] cluster_iso_ack_i,
  output logic                   err_irq_o
);

  localparam logic [11:0] AddrCtrl    = 12'h000;
  localparam logic [11:0] AddrStatus  = 12'h004;
  localparam logic [11:0] AddrBusy    = 12'h008;
  localparam logic [11:0] AddrErr     = 12'h00C;
  localparam logic [11:0] AddrTimeout = 12'h010;

  localparam logic [15:0] SettleLast = 16'(ClkSettleCycles - 1);

  typedef enum logic [2:0] {
    StOff,
    StPuClk,
    StPuRst,
    StPuIso,
    StOn,
    StPdIso,
    StPdRst,
    StPdClk
  } state_e;

  state_e state_q [NumClusters];
  state_e state_d [NumClusters];
  logic [15:0] cnt_q [NumClusters];
  logic [15:0] cnt_d [NumClusters];

  logic [NumClusters-1:0] ctrl_q;
  logic [NumClusters-1:0] err_q, err_d, err_set, err_clr;
  logic [15:0]            timeout_q;

  logic [NumClusters-1:0] clk_en, rst_out, iso, on, busy;
  logic                   access, wr, ctrl_we, timeout_we;
  logic [11:0]            offset;

  logic unused_apb;
  assign unused_apb = ^{apb_req_i.paddr[31:12], apb_req_i.pprot, apb_req_i.pstrb};

  assign access = apb_req_i.psel & apb_req_i.penable;
  assign wr     = access & apb_req_i.pwrite;
  assign offset = apb_req_i.paddr[11:0];

  // Register decode and read mux; zero wait states.
  always_comb begin
    apb_rsp_o        = '0;
    apb_rsp_o.pready = 1'b1;
    ctrl_we          = 1'b0;
    timeout_we       = 1'b0;
    err_clr          = '0;
    if (access) begin
      unique case (offset)
        AddrCtrl: begin
          apb_rsp_o.prdata[NumClusters-1:0] = ctrl_q;
          ctrl_we = wr;
        end
        AddrStatus: apb_rsp_o.prdata[NumClusters-1:0] = on;
        AddrBusy:   apb_rsp_o.prdata[NumClusters-1:0] = busy;
        AddrErr: begin
          apb_rsp_o.prdata[NumClusters-1:0] = err_q;
          if (wr) begin
            err_clr = apb_req_i.pwdata[NumClusters-1:0];
          end
        end
        AddrTimeout: begin
          apb_rsp_o.prdata[15:0] = timeout_q;
          timeout_we = wr;
        end
        default: apb_rsp_o.pslverr = 1'b1;
      endcase
    end
  end

  // Per-cluster sequencer; cnt_q doubles as settle counter and ack timeout counter.
  always_comb begin
    clk_en  = '1;
    rst_out = '0;
    iso     = '0;
    on      = '0;
    busy    = '1;
    err_set = '0;
    for (int i = 0; i < NumClusters; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i] + 16'd1;
      unique case (state_q[i])
        StOff: begin
          clk_en[i]  = 1'b0;
          rst_out[i] = 1'b1;
          iso[i]     = 1'b1;
          busy[i]    = 1'b0;
          cnt_d[i]   = '0;
          if (ctrl_q[i]) begin
            state_d[i] = StPuClk;
          end
        end
        StPuClk: begin
          rst_out[i] = 1'b1;
          iso[i]     = 1'b1;
          if (cnt_q[i] == SettleLast) begin
            state_d[i] = StPuRst;
          end
        end
        StPuRst: begin
          iso[i]     = 1'b1;
          cnt_d[i]   = '0;
          state_d[i] = StPuIso;
        end
        StPuIso: begin
          if (!cluster_iso_ack_i[i]) begin
            state_d[i] = StOn;
          end else if (timeout_q != '0 && cnt_q[i] == timeout_q - 16'd1) begin
            state_d[i] = StOn;
            err_set[i] = 1'b1;
          end
        end
        StOn: begin
          on[i]    = 1'b1;
          busy[i]  = 1'b0;
          cnt_d[i] = '0;
          if (!ctrl_q[i]) begin
            state_d[i] = StPdIso;
          end
        end
        StPdIso: begin
          iso[i] = 1'b1;
          if (cluster_iso_ack_i[i]) begin
            state_d[i] = StPdRst;
          end else if (timeout_q != '0 && cnt_q[i] == timeout_q - 16'd1) begin
            state_d[i] = StPdRst;
            err_set[i] = 1'b1;
          end
        end
        StPdRst: begin
          rst_out[i] = 1'b1;
          iso[i]     = 1'b1;
          state_d[i] = StPdClk;
        end
        StPdClk: begin
          clk_en[i]  = 1'b0;
          rst_out[i] = 1'b1;
          iso[i]     = 1'b1;
          state_d[i] = StOff;
        end
        default: state_d[i] = StOff;
      endcase
    end
  end

  // A timeout flagged in the same cycle as a W1C clear stays set.
  assign err_d = (err_q & ~err_clr) | err_set;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= BootOnMask;
      err_q     <= '0;
      timeout_q <= DefaultTimeout;
      for (int i = 0; i < NumClusters; i++) begin
        state_q[i] <= BootOnMask[i] ? StOn : StOff;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (ctrl_we) begin
        ctrl_q <= apb_req_i.pwdata[NumClusters-1:0];
      end
      if (timeout_we) begin
        timeout_q <= apb_req_i.pwdata[15:0];
      end
      err_q <= err_d;
      for (int i = 0; i < NumClusters; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign cluster_clk_en_o = clk_en;
  assign cluster_rst_o    = rst_out;
  assign cluster_iso_o    = iso;
  assign err_irq_o        = |err_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scoreboard bench: a phase-list model predicts every cycle's cluster outputs and each APB
// response; a monitor compares them on the falling edge.

module tb_chimera_cluster_pwr_seq;
  import chimera_cluster_pwr_seq_pkg::*;

  localparam int unsigned    N      = 5;
  localparam int unsigned    Settle = 4;
  localparam logic [15:0]    DefTmo = 16'd256;
  localparam logic [N-1:0]   Boot   = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  apb_req_t  req;
  apb_resp_t rsp;
  logic [N-1:0] clk_en, crst, iso, ack;
  logic irq;

  always #5 clk = ~clk;

  chimera_cluster_pwr_seq #(
    .NumClusters    (N),
    .ClkSettleCycles(Settle),
    .DefaultTimeout (DefTmo),
    .BootOnMask     (Boot),
    .apb_req_t      (apb_req_t),
    .apb_rsp_t      (apb_resp_t)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .apb_req_i        (req),
    .apb_rsp_o        (rsp),
    .cluster_clk_en_o (clk_en),
    .cluster_rst_o    (crst),
    .cluster_iso_o    (iso),
    .cluster_iso_ack_i(ack),
    .err_irq_o        (irq)
  );

  // Isolation unit stand-in: ack follows iso after 0..2 cycles, or never acknowledges.
  int unsigned  ack_dly   [N];
  bit           ack_stuck [N];
  logic [N-1:0] iso_d1 = '1, iso_d2 = '1;
  always @(posedge clk) begin
    iso_d1 <= iso;
    iso_d2 <= iso_d1;
  end
  always_comb begin
    ack = '0;
    for (int i = 0; i < N; i++) begin
      if (ack_stuck[i])          ack[i] = ~iso[i];
      else if (ack_dly[i] == 0)  ack[i] = iso[i];
      else if (ack_dly[i] == 1)  ack[i] = iso_d1[i];
      else                       ack[i] = iso_d2[i];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic clk_en; logic rst; logic iso; logic on; logic busy; logic set_err;
  } step_t;
  typedef struct packed {
    logic [N-1:0] clk_en; logic [N-1:0] rst; logic [N-1:0] iso; logic irq;
  } outs_t;
  typedef struct {
    logic [31:0] data; bit err; bit chk_data;
  } rd_t;

  step_t        cur       [N];
  step_t        plan_step [N][4];
  int           plan_cnt  [N][4];
  int           plan_idx  [N];
  logic [N-1:0] m_ctrl, m_err;
  logic [15:0]  m_tmo;
  outs_t        exp_q [$];
  rd_t          rd_q  [$];
  int           errors = 0;
  int           checks = 0;

  function automatic step_t st(input bit c, input bit r, input bit s, input bit o, input bit b,
                               input bit e);
    return step_t'({c, r, s, o, b, e});
  endfunction

  // Each sequence is a list of (output row, cycles); ISO length follows from ack delay and TIMEOUT.
  task automatic build(input int i);
    int dur;
    bit e;
    int t = int'(m_tmo);
    if (ack_stuck[i]) begin
      dur = t; e = 1'b1;
    end else if (t != 0 && int'(ack_dly[i]) > t - 1) begin
      dur = t; e = 1'b1;
    end else begin
      dur = int'(ack_dly[i]) + 1; e = 1'b0;
    end
    if (!cur[i].on) begin
      plan_step[i][0] = st(1, 1, 1, 0, 1, 0); plan_cnt[i][0] = Settle;
      plan_step[i][1] = st(1, 0, 1, 0, 1, 0); plan_cnt[i][1] = 1;
      plan_step[i][2] = st(1, 0, 0, 0, 1, 0); plan_cnt[i][2] = dur;
      plan_step[i][3] = st(1, 0, 0, 1, 0, e); plan_cnt[i][3] = 1;
    end else begin
      plan_step[i][0] = st(1, 0, 1, 0, 1, 0); plan_cnt[i][0] = dur;
      plan_step[i][1] = st(1, 1, 1, 0, 1, e); plan_cnt[i][1] = 1;
      plan_step[i][2] = st(0, 1, 1, 0, 1, 0); plan_cnt[i][2] = 1;
      plan_step[i][3] = st(0, 1, 1, 0, 0, 0); plan_cnt[i][3] = 1;
    end
    plan_idx[i] = 0;
  endtask

  function automatic bit bus_wr(input logic [31:0] addr);
    return req.psel && req.penable && req.pwrite && req.paddr == addr;
  endfunction

  initial begin
    logic [N-1:0] set_v, clr_v;
    outs_t o;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          cur[i] = Boot[i] ? st(1, 0, 0, 1, 0, 0) : st(0, 1, 1, 0, 0, 0);
          plan_idx[i] = 4;
        end
        m_ctrl = Boot; m_err = '0; m_tmo = DefTmo;
      end else begin
        set_v = '0;
        for (int i = 0; i < N; i++) begin
          if (plan_idx[i] == 4 && cur[i].on != m_ctrl[i]) build(i);
          if (plan_idx[i] < 4) begin
            cur[i]   = plan_step[i][plan_idx[i]];
            set_v[i] = cur[i].set_err;
            plan_cnt[i][plan_idx[i]] -= 1;
            if (plan_cnt[i][plan_idx[i]] == 0) plan_idx[i] += 1;
          end
        end
        clr_v = bus_wr(32'h0C) ? req.pwdata[N-1:0] : '0;
        m_err = (m_err & ~clr_v) | set_v;
        if (bus_wr(32'h00)) m_ctrl = req.pwdata[N-1:0];
        if (bus_wr(32'h10)) m_tmo  = req.pwdata[15:0];
      end
      for (int i = 0; i < N; i++) begin
        o.clk_en[i] = cur[i].clk_en;
        o.rst[i]    = cur[i].rst;
        o.iso[i]    = cur[i].iso;
      end
      o.irq = |m_err;
      exp_q.push_back(o);
    end
  end

  function automatic bit model_idle();
    for (int i = 0; i < N; i++) begin
      if (plan_idx[i] != 4 || cur[i].on != m_ctrl[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic rd_t exp_rd(input logic [31:0] addr, input bit write);
    rd_t r;
    r.data = '0; r.err = 1'b0; r.chk_data = !write;
    case (addr)
      32'h00: r.data[N-1:0] = m_ctrl;
      32'h04: for (int i = 0; i < N; i++) r.data[i] = cur[i].on;
      32'h08: for (int i = 0; i < N; i++) r.data[i] = cur[i].busy;
      32'h0C: r.data[N-1:0] = m_err;
      32'h10: r.data[15:0] = m_tmo;
      default: begin r.err = 1'b1; r.chk_data = 1'b1; end
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    outs_t e;
    rd_t   r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({clk_en, crst, iso, irq} !== {e.clk_en, e.rst, e.iso, e.irq}) begin
          errors++;
          $display("FAIL outputs t=%0t clk_en=%b want %b rst=%b want %b iso=%b want %b irq=%b want %b",
                   $time, clk_en, e.clk_en, crst, e.rst, iso, e.iso, irq, e.irq);
        end
      end
      if (req.psel && req.penable) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL apb_unexpected t=%0t no expected response queued", $time);
        end else begin
          r = rd_q.pop_front();
          if (rsp.pready !== 1'b1 || rsp.pslverr !== r.err ||
              (r.chk_data && rsp.prdata !== r.data)) begin
            errors++;
            $display("FAIL apb addr=%h t=%0t prdata=%h want %h pslverr=%b want %b pready=%b want 1",
                     req.paddr, $time, rsp.prdata, r.data, rsp.pslverr, r.err, rsp.pready);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input logic [31:0] addr, input bit write, input logic [31:0] wdata);
    @(posedge clk); #1;
    req.paddr = addr; req.pwrite = write; req.pwdata = wdata; req.pstrb = 4'hF;
    req.psel = 1'b1; req.penable = 1'b0;
    @(posedge clk); #1;
    req.penable = 1'b1;
    rd_q.push_back(exp_rd(addr, write));
    @(posedge clk); #1;
    req.psel = 1'b0; req.penable = 1'b0; req.pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    apb(addr, 1'b1, wdata);
  endtask

  task automatic apb_read(input logic [31:0] addr);
    apb(addr, 1'b0, 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!model_idle() && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!model_idle()) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout t=%0t sequencers still busy after %0d cycles", $time, n);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic reconfigure();
    logic [15:0] tmo_tab [6];
    logic [15:0] t;
    tmo_tab = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    wait_idle();
    t = tmo_tab[$urandom_range(0, 5)];
    for (int i = 0; i < N; i++) begin
      ack_dly[i]   = $urandom_range(0, 2);
      ack_stuck[i] = (t != 0) && ($urandom_range(0, 3) == 0);
    end
    apb_write(32'h10, {16'h0, t});
  endtask

  initial begin
    logic [31:0] addr_tab [6];
    addr_tab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    req = '0;
    for (int i = 0; i < N; i++) begin
      ack_dly[i] = 0;
      ack_stuck[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values of every register.
    for (int k = 0; k < 5; k++) apb_read(addr_tab[k]);

    // Power up cluster 1 with ack following iso immediately.
    apb_write(32'h00, 32'h3);
    wait_idle();
    apb_read(32'h04);

    // Power down cluster 0 with no ack and TIMEOUT=3, then clear the sticky error.
    apb_write(32'h10, 32'd3);
    ack_stuck[0] = 1'b1;
    apb_write(32'h00, 32'h2);
    wait_idle();
    apb_read(32'h0C);
    apb_write(32'h0C, 32'h1);
    apb_read(32'h0C);
    ack_stuck[0] = 1'b0;

    // Drop CTRL while cluster 1 is still settling its clock.
    apb_write(32'h00, 32'h0);
    wait_idle();
    apb_write(32'h00, 32'h2);
    apb_write(32'h00, 32'h0);
    apb_read(32'h08);
    wait_idle();

    // Bad offset, then all-ones CTRL powering every cluster at once.
    apb_read(32'h14);
    apb_write(32'h14, 32'hFFFF_FFFF);
    apb_write(32'h00, 32'hFFFF_FFFF);
    apb_read(32'h00);
    apb_read(32'h08);
    wait_idle();
    apb_read(32'h04);

    // Reset while cluster 2 waits in power-down isolation.
    apb_write(32'h10, 32'd200);
    ack_stuck[2] = 1'b1;
    apb_write(32'h00, 32'h1B);
    repeat (5) @(posedge clk);
    pulse_reset();
    ack_stuck[2] = 1'b0;
    apb_read(32'h0C);
    apb_read(32'h04);
    apb_read(32'h00);
    apb_read(32'h10);

    // Randomised traffic with varied ack delays and timeouts.
    for (int it = 0; it < 80; it++) begin
      int op = $urandom_range(0, 9);
      if (op < 4)      apb_write(32'h00, $urandom);
      else if (op < 8) apb_read(addr_tab[$urandom_range(0, 5)]);
      else             reconfigure();
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    wait_idle();
    apb_read(32'h04);
    apb_read(32'h0C);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
